// File: rtl/or_arb_pkg.sv
// Shared state encodings and requester IDs for the two-client OR arbiter.
package or_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OPER = 2'b01,
    HOLD = 2'b10
  } arb_state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // One-hot grant vector {gnt1, gnt0} for a requester ID.
  function automatic logic [1:0] id_to_gnt(input logic id);
    return (id == REQ1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/sc_or_arbiter_if.sv
// Bus bundle joining the arbiter to its two requesters, the shared OR unit and the result consumer.
interface sc_or_arbiter_if #(
  parameter int NUMBER_DATAWIDTH = 8
);
  logic                        OR_ARB_req0_In;
  logic [NUMBER_DATAWIDTH-1:0] OR_ARB_req0_data0_In;
  logic [NUMBER_DATAWIDTH-1:0] OR_ARB_req0_data1_In;
  logic                        OR_ARB_gnt0_Out;
  logic                        OR_ARB_req1_In;
  logic [NUMBER_DATAWIDTH-1:0] OR_ARB_req1_data0_In;
  logic [NUMBER_DATAWIDTH-1:0] OR_ARB_req1_data1_In;
  logic                        OR_ARB_gnt1_Out;
  logic [NUMBER_DATAWIDTH-1:0] OR_ARB_or_data0_Out;
  logic [NUMBER_DATAWIDTH-1:0] OR_ARB_or_data1_Out;
  logic [NUMBER_DATAWIDTH-1:0] OR_ARB_or_z_In;
  logic [NUMBER_DATAWIDTH-1:0] OR_ARB_result_Out;
  logic                        OR_ARB_result_valid_Out;
  logic                        OR_ARB_result_id_Out;
  logic                        OR_ARB_result_ready_In;

  modport master (
    input  OR_ARB_req0_In, OR_ARB_req0_data0_In, OR_ARB_req0_data1_In,
    input  OR_ARB_req1_In, OR_ARB_req1_data0_In, OR_ARB_req1_data1_In,
    input  OR_ARB_or_z_In, OR_ARB_result_ready_In,
    output OR_ARB_gnt0_Out, OR_ARB_gnt1_Out,
    output OR_ARB_or_data0_Out, OR_ARB_or_data1_Out,
    output OR_ARB_result_Out, OR_ARB_result_valid_Out, OR_ARB_result_id_Out
  );

  modport slave (
    output OR_ARB_req0_In, OR_ARB_req0_data0_In, OR_ARB_req0_data1_In,
    output OR_ARB_req1_In, OR_ARB_req1_data0_In, OR_ARB_req1_data1_In,
    output OR_ARB_or_z_In, OR_ARB_result_ready_In,
    input  OR_ARB_gnt0_Out, OR_ARB_gnt1_Out,
    input  OR_ARB_or_data0_Out, OR_ARB_or_data1_Out,
    input  OR_ARB_result_Out, OR_ARB_result_valid_Out, OR_ARB_result_id_Out
  );

endinterface

// File: rtl/sc_or_arb_pick.sv
// Combinational winner select for the OR arbiter.
// Define OR_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round robin.
module sc_or_arb_pick
  import or_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic winner,
  output logic any_req
);

  always_comb begin
    any_req = req0 | req1;
    winner  = REQ0;
    if (req0 && req1) begin
`ifdef OR_ARB_FIXED_PRIO_EN
      winner = REQ0;
`else
      winner = (last_grant == REQ0) ? REQ1 : REQ0;
`endif
    end else if (req1) begin
      winner = REQ1;
    end
  end

`ifdef OR_ARB_FIXED_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

endmodule

// File: rtl/sc_or_arbiter.sv
// Shares one external 8-bit OR unit between two requesters; registered result with valid/ready.
// Tie-break policy selected in sc_or_arb_pick by OR_ARB_FIXED_PRIO_EN (undefined: round robin).
module sc_or_arbiter
  import or_arb_pkg::*;
#(
  parameter int NUMBER_DATAWIDTH = 8
) (
  input logic             OR_ARB_CLOCK_50,
  input logic             OR_ARB_RESET_InLow,
  sc_or_arbiter_if.master bus
);

  arb_state_t                  state_q, state_d;
  logic [NUMBER_DATAWIDTH-1:0] opa_q, opa_d;
  logic [NUMBER_DATAWIDTH-1:0] opb_q, opb_d;
  logic [NUMBER_DATAWIDTH-1:0] res_q, res_d;
  logic [1:0]                  gnt_q, gnt_d;
  logic                        valid_q, valid_d;
  logic                        id_q, id_d;
  logic                        last_q, last_d;
  logic                        winner;
  logic                        any_req;

  sc_or_arb_pick u_pick (
    .req0       (bus.OR_ARB_req0_In),
    .req1       (bus.OR_ARB_req1_In),
    .last_grant (last_q),
    .winner     (winner),
    .any_req    (any_req)
  );

  always_ff @(posedge OR_ARB_CLOCK_50 or negedge OR_ARB_RESET_InLow) begin
    if (!OR_ARB_RESET_InLow) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      gnt_q   <= 2'b00;
      valid_q <= 1'b0;
      id_q    <= REQ0;
      last_q  <= REQ1;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      last_q  <= last_d;
    end
  end

  // Grant is a one-cycle pulse; everything else holds unless a state transition updates it.
  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    gnt_d   = 2'b00;
    valid_d = valid_q;
    id_d    = id_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          opa_d   = (winner == REQ1) ? bus.OR_ARB_req1_data0_In : bus.OR_ARB_req0_data0_In;
          opb_d   = (winner == REQ1) ? bus.OR_ARB_req1_data1_In : bus.OR_ARB_req0_data1_In;
          gnt_d   = id_to_gnt(winner);
          id_d    = winner;
          state_d = OPER;
        end
      end
      OPER: begin
        res_d   = bus.OR_ARB_or_z_In;
        valid_d = 1'b1;
        last_d  = id_q;
        state_d = HOLD;
      end
      HOLD: begin
        if (bus.OR_ARB_result_ready_In) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.OR_ARB_gnt0_Out         = gnt_q[0];
  assign bus.OR_ARB_gnt1_Out         = gnt_q[1];
  assign bus.OR_ARB_or_data0_Out     = opa_q;
  assign bus.OR_ARB_or_data1_Out     = opb_q;
  assign bus.OR_ARB_result_Out       = res_q;
  assign bus.OR_ARB_result_valid_Out = valid_q;
  assign bus.OR_ARB_result_id_Out    = id_q;

endmodule
